pixel_painter: RTL and testbench
================================

# pixel_painter

Write-side engine for the pixel store: accepts pen stamp and screen-clear requests and emits one pixel write per clock (x, y, 3-bit colour code) into the frame store. The RGB lookup path reads the same store, so this block is its writer. Sits between the pen/input controller and the pixel store's write port.

## Interface
- H_ACTIVE, 640: visible width in pixels; writes with x ≥ H_ACTIVE are suppressed.
- V_ACTIVE, 480: visible height in pixels; writes with y ≥ V_ACTIVE are suppressed.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- stroke_valid  in  1  stamp request valid.
- stroke_ready  out  1  block can accept a stamp or clear.
- pen_x, pen_y  in  10 each  stamp centre; sampled on acceptance.
- color  in  3  colour code: 1 red, 2 green, 3 blue, 4 yellow, 5 purple, 6 white, 7 erase; 0 is a no-op.
- brush  in  2  brush radius r; the stamp is a (2r+1)×(2r+1) square.
- clear_req  in  1  request to fill the whole screen with erase (7); sampled when stroke_ready=1.
- wr_en  out  1  pixel write strobe.
- wr_x, wr_y  out  10 each  write address.
- wr_color  out  3  write data.
- done  out  1  one-cycle pulse when a stamp or clear finishes.

## Operation
- States: IDLE, STAMP, CLEAR.
- IDLE: stroke_ready=1. If clear_req=1 → CLEAR, even if stroke_valid=1 in the same cycle; the stroke is not accepted. Otherwise, if stroke_valid=1 → stroke accepted, and pen_x, pen_y, color and brush are latched.
  - Accepted stroke with color=0 → stays in IDLE and pulses done the next cycle; no writes.
  - Accepted stroke with color≠0 → STAMP.
- STAMP: raster over dx, dy ∈ [−r, +r], row-major (dy outer, dx inner, both ascending). Coordinates are computed in 11-bit signed: x = pen_x + dx, y = pen_y + dy.
  - Visited pixel with x<0, y<0, x≥H_ACTIVE or y≥V_ACTIVE → wr_en=0 for that cycle. It still consumes the cycle.
  - After the last pixel → IDLE.
- CLEAR: raster x 0..H_ACTIVE−1 inner, y 0..V_ACTIVE−1 outer, wr_color=7, wr_en=1 every cycle. After (H_ACTIVE−1, V_ACTIVE−1) → IDLE.
- stroke_ready=0 in STAMP and CLEAR. Inputs are ignored while busy; requests are not queued.
- wr_x and wr_y hold their last value when wr_en=0. Neither output wraps: clipped coordinates never appear with wr_en=1.
- Reset asserted mid-stamp or mid-clear aborts the operation immediately. No further writes and no done pulse.

## Timing
- All outputs are registered.
- Reset values: stroke_ready=1 (combinational from state=IDLE), wr_en=0, wr_x=0, wr_y=0, wr_color=0, done=0, state=IDLE.
- Stroke accepted at edge N:
  - First write cycle is N+1.
  - Stamp occupies exactly (2r+1)² cycles: 1, 9, 25 or 49.
  - done pulses in the cycle after the last write cycle, and stroke_ready returns to 1 in that same cycle.
  - Back-to-back accept is therefore possible on the done cycle.
- Clear occupies H_ACTIVE·V_ACTIVE cycles (307200 at defaults), followed by the done cycle.
- color=0 stroke: done at N+1, stroke_ready stays 1.

## Structure
- Shared package paint_pkg holds:
  - colour-code localparams (RED…ERASE, NONE=0);
  - RGB triples;
  - a state enum typedef.
- The RGB lookup path imports the same package.
- One sub-module, raster_scan: a two-dimensional counter with programmable start/end per axis, plus first/last flags. It is instantiated once and reused by both STAMP and CLEAR.

## Test plan
- Stroke at (100,50), color=1, brush=1 → 9 writes with wr_color=1, x in 99..101 and y in 49..51 in row-major order; done at cycle 10 after accept.
- Stroke at (0,0), brush=2 → 25 cycles with only 9 writes, covering x, y ∈ 0..2; no wr_en with wrapped coordinates.
- Stroke at (639,479), brush=3 → 49 cycles with 16 writes, x ∈ 636..639, y ∈ 476..479.
- clear_req and stroke_valid asserted together in IDLE → clear wins:
  - 307200 writes of colour 7 ending at (639,479), then done;
  - the stroke is not consumed while stroke_valid is held, and it is accepted on the done cycle.
- color=0 stroke → no wr_en, done at N+1.
- reset_n asserted at write 5 of a 25-pixel stamp → wr_en=0 and stroke_ready=1 immediately; no done pulse; the next stroke behaves normally.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared definitions for the pixel store: colour codes, their RGB values and
// the painter state encoding. The RGB lookup path imports this same package.
package paint_pkg;

  localparam int COORD_W = 11;

  localparam logic [2:0] NONE   = 3'd0;
  localparam logic [2:0] RED    = 3'd1;
  localparam logic [2:0] GREEN  = 3'd2;
  localparam logic [2:0] BLUE   = 3'd3;
  localparam logic [2:0] YELLOW = 3'd4;
  localparam logic [2:0] PURPLE = 3'd5;
  localparam logic [2:0] WHITE  = 3'd6;
  localparam logic [2:0] ERASE  = 3'd7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_NONE   = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_RED    = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_GREEN  = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t RGB_BLUE   = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t RGB_YELLOW = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t RGB_PURPLE = '{r: 8'h80, g: 8'h00, b: 8'h80};
  localparam rgb_t RGB_WHITE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t RGB_ERASE  = '{r: 8'h00, g: 8'h00, b: 8'h00};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAMP = 2'd1,
    ST_CLEAR = 2'd2
  } paint_state_t;

  function automatic rgb_t code_to_rgb(input logic [2:0] code);
    case (code)
      RED:     return RGB_RED;
      GREEN:   return RGB_GREEN;
      BLUE:    return RGB_BLUE;
      YELLOW:  return RGB_YELLOW;
      PURPLE:  return RGB_PURPLE;
      WHITE:   return RGB_WHITE;
      ERASE:   return RGB_ERASE;
      default: return RGB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/raster_scan.sv
// Two-dimensional raster counter: x runs inner from start to end, y outer.
// The position after the current one is exposed so the caller can register it.
module raster_scan
  import paint_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_load,
  input  logic                      i_step,
  input  logic signed [COORD_W-1:0] i_x_start,
  input  logic signed [COORD_W-1:0] i_x_end,
  input  logic signed [COORD_W-1:0] i_y_start,
  input  logic signed [COORD_W-1:0] i_y_end,
  output logic signed [COORD_W-1:0] o_x,
  output logic signed [COORD_W-1:0] o_y,
  output logic signed [COORD_W-1:0] o_next_x,
  output logic signed [COORD_W-1:0] o_next_y,
  output logic                      o_first,
  output logic                      o_last
);

  logic signed [COORD_W-1:0] r_x;
  logic signed [COORD_W-1:0] r_y;
  logic signed [COORD_W-1:0] r_x_start;
  logic signed [COORD_W-1:0] r_x_end;
  logic signed [COORD_W-1:0] r_y_end;
  logic                      r_first;
  logic                      w_row_end;

  assign w_row_end = (r_x == r_x_end);

  always_comb begin
    o_next_x = r_x + 11'sd1;
    o_next_y = r_y;
    if (w_row_end) begin
      o_next_x = r_x_start;
      o_next_y = r_y + 11'sd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_x_start <= '0;
      r_x_end   <= '0;
      r_y_end   <= '0;
      r_first   <= 1'b0;
    end else if (i_load) begin
      r_x       <= i_x_start;
      r_y       <= i_y_start;
      r_x_start <= i_x_start;
      r_x_end   <= i_x_end;
      r_y_end   <= i_y_end;
      r_first   <= 1'b1;
    end else if (i_step) begin
      r_x     <= o_next_x;
      r_y     <= o_next_y;
      r_first <= 1'b0;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_first = r_first;
  assign o_last  = w_row_end && (r_y == r_y_end);

endmodule

// File: rtl/pixel_painter.sv
// Write-side engine of the pixel store: turns pen stamps and screen clears
// into one clipped pixel write per clock.
module pixel_painter
  import paint_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stroke_valid,
  output logic       stroke_ready,
  input  logic [9:0] pen_x,
  input  logic [9:0] pen_y,
  input  logic [2:0] color,
  input  logic [1:0] brush,
  input  logic       clear_req,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [2:0] wr_color,
  output logic       done
);

  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  paint_state_t r_state;
  paint_state_t w_state_nxt;

  logic [2:0] r_color;
  logic       r_wr_en;
  logic [9:0] r_wr_x;
  logic [9:0] r_wr_y;
  logic [2:0] r_wr_color;
  logic       r_done;

  logic signed [COORD_W-1:0] w_pen_x;
  logic signed [COORD_W-1:0] w_pen_y;
  logic signed [COORD_W-1:0] w_rad;
  logic signed [COORD_W-1:0] w_xs;
  logic signed [COORD_W-1:0] w_xe;
  logic signed [COORD_W-1:0] w_ys;
  logic signed [COORD_W-1:0] w_ye;
  logic signed [COORD_W-1:0] w_scan_x;
  logic signed [COORD_W-1:0] w_scan_y;
  logic signed [COORD_W-1:0] w_next_x;
  logic signed [COORD_W-1:0] w_next_y;
  logic signed [COORD_W-1:0] w_pix_x;
  logic signed [COORD_W-1:0] w_pix_y;
  logic [2:0] w_pix_color;
  logic       w_scan_first_unused;
  logic       w_scan_last;
  logic       w_busy;
  logic       w_load;
  logic       w_load_clear;
  logic       w_step;
  logic       w_wr_en_nxt;
  logic       w_done_nxt;

  function automatic logic on_screen(input logic signed [COORD_W-1:0] x,
                                     input logic signed [COORD_W-1:0] y);
    return !x[COORD_W-1] && !y[COORD_W-1] && (x <= X_MAX) && (y <= Y_MAX);
  endfunction

  assign w_pen_x = $signed({1'b0, pen_x});
  assign w_pen_y = $signed({1'b0, pen_y});
  assign w_rad   = $signed({{(COORD_W-2){1'b0}}, brush});
  assign w_busy  = (r_state != ST_IDLE);

  // Scan window: whole screen for a clear, the brush square for a stamp
  always_comb begin
    w_xs = w_pen_x - w_rad;
    w_xe = w_pen_x + w_rad;
    w_ys = w_pen_y - w_rad;
    w_ye = w_pen_y + w_rad;
    if (clear_req) begin
      w_xs = '0;
      w_xe = X_MAX;
      w_ys = '0;
      w_ye = Y_MAX;
    end
  end

  raster_scan u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_x_start (w_xs),
    .i_x_end   (w_xe),
    .i_y_start (w_ys),
    .i_y_end   (w_ye),
    .o_x       (w_scan_x),
    .o_y       (w_scan_y),
    .o_next_x  (w_next_x),
    .o_next_y  (w_next_y),
    .o_first   (w_scan_first_unused),
    .o_last    (w_scan_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_clear = 1'b0;
    w_step       = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt  = ST_CLEAR;
          w_load       = 1'b1;
          w_load_clear = 1'b1;
        end else if (stroke_valid) begin
          if (color == NONE) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_STAMP;
            w_load      = 1'b1;
          end
        end
      end
      ST_STAMP, ST_CLEAR: begin
        if (w_scan_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The pixel emitted at this edge is the scan start on a load, otherwise the
  // position the scanner is about to move to.
  always_comb begin
    w_pix_x     = w_next_x;
    w_pix_y     = w_next_y;
    w_pix_color = r_color;
    if (w_load) begin
      w_pix_x     = w_xs;
      w_pix_y     = w_ys;
      w_pix_color = w_load_clear ? ERASE : color;
    end
    w_wr_en_nxt = (w_load || w_step) && on_screen(w_pix_x, w_pix_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_color    <= NONE;
      r_wr_en    <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= NONE;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_color <= w_pix_color;
      end
      if (w_wr_en_nxt) begin
        r_wr_x     <= w_pix_x[9:0];
        r_wr_y     <= w_pix_y[9:0];
        r_wr_color <= w_pix_color;
      end
    end
  end

  assign stroke_ready = !w_busy;
  assign wr_en        = r_wr_en;
  assign wr_x         = r_wr_x;
  assign wr_y         = r_wr_y;
  assign wr_color     = r_wr_color;
  assign done         = r_done;

endmodule

// File: tb/tb_pixel_painter.sv
// Directed and randomized bench for pixel_painter; expected writes come from
// enumerating the brush square and clip window in plain integer arithmetic.
module tb_pixel_painter;

  localparam int H = 160;
  localparam int V = 120;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stroke_valid;
  logic       stroke_ready;
  logic [9:0] pen_x;
  logic [9:0] pen_y;
  logic [2:0] color;
  logic [1:0] brush;
  logic       clear_req;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_color;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int held_x = 0;
  int held_y = 0;

  pixel_painter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stroke_valid (stroke_valid),
    .stroke_ready (stroke_ready),
    .pen_x        (pen_x),
    .pen_y        (pen_y),
    .color        (color),
    .brush        (brush),
    .clear_req    (clear_req),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks from the first cycle after acceptance through the done cycle.
  task automatic check_stamp(input int px, input int py, input int col, input int r);
    int n_wr = 0;
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        int  x = px + dx;
        int  y = py + dy;
        bit  vis = (x >= 0) && (x < H) && (y >= 0) && (y < V);
        chk("stamp_ready", 32'(stroke_ready), 32'd0);
        chk("stamp_done", 32'(done), 32'd0);
        chk("stamp_wr_en", 32'(wr_en), 32'(vis));
        if (vis) begin
          held_x = x;
          held_y = y;
          n_wr++;
          chk("stamp_color", 32'(wr_color), 32'(col));
        end
        chk("stamp_x", 32'(wr_x), 32'(held_x));
        chk("stamp_y", 32'(wr_y), 32'(held_y));
        tick();
      end
    end
    chk("stamp_end_done", 32'(done), 32'd1);
    chk("stamp_end_ready", 32'(stroke_ready), 32'd1);
    chk("stamp_end_wr_en", 32'(wr_en), 32'd0);
  endtask

  task automatic do_stroke(input int px, input int py, input int col, input int r);
    stroke_valid = 1'b1;
    pen_x = 10'(px);
    pen_y = 10'(py);
    color = 3'(col);
    brush = 2'(r);
    tick();
    stroke_valid = 1'b0;
    check_stamp(px, py, col, r);
  endtask

  initial begin
    reset_n      = 1'b0;
    stroke_valid = 1'b0;
    clear_req    = 1'b0;
    pen_x        = '0;
    pen_y        = '0;
    color        = '0;
    brush        = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(stroke_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_x", 32'(wr_x), 32'd0);
    chk("rst_wr_y", 32'(wr_y), 32'd0);
    chk("rst_wr_color", 32'(wr_color), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    do_stroke(100, 50, 1, 1);
    tick();
    do_stroke(0, 0, 2, 2);
    tick();
    do_stroke(H - 1, V - 1, 5, 3);

    // color 0: done next cycle, no writes, ready stays high
    tick();
    stroke_valid = 1'b1;
    pen_x = 10'd30;
    pen_y = 10'd30;
    color = 3'd0;
    brush = 2'd1;
    tick();
    stroke_valid = 1'b0;
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_ready", 32'(stroke_ready), 32'd1);
    chk("nop_wr_en", 32'(wr_en), 32'd0);
    tick();
    chk("nop_done_clr", 32'(done), 32'd0);
    chk("nop_wr_en2", 32'(wr_en), 32'd0);

    // clear wins over a simultaneous stroke; the held stroke is taken on done
    stroke_valid = 1'b1;
    pen_x = 10'd20;
    pen_y = 10'd30;
    color = 3'd3;
    brush = 2'd1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        chk("clr_wr_en", 32'(wr_en), 32'd1);
        chk("clr_x", 32'(wr_x), 32'(x));
        chk("clr_y", 32'(wr_y), 32'(y));
        chk("clr_color", 32'(wr_color), 32'd7);
        chk("clr_ready", 32'(stroke_ready), 32'd0);
        tick();
      end
    end
    held_x = H - 1;
    held_y = V - 1;
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_end_ready", 32'(stroke_ready), 32'd1);
    chk("clr_end_wr_en", 32'(wr_en), 32'd0);
    tick();
    stroke_valid = 1'b0;
    check_stamp(20, 30, 3, 1);

    // reset during write 5 of a 25-pixel stamp
    tick();
    stroke_valid = 1'b1;
    pen_x = 10'd50;
    pen_y = 10'd40;
    color = 3'd6;
    brush = 2'd2;
    tick();
    stroke_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rs_wr_en", 32'(wr_en), 32'd1);
      chk("rs_x", 32'(wr_x), 32'(48 + k));
      chk("rs_y", 32'(wr_y), 32'd38);
      if (k < 4) tick();
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("rs_abort_wr_en", 32'(wr_en), 32'd0);
    chk("rs_abort_ready", 32'(stroke_ready), 32'd1);
    chk("rs_abort_done", 32'(done), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    held_x = 0;
    held_y = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs_after_done", 32'(done), 32'd0);
      chk("rs_after_wr_en", 32'(wr_en), 32'd0);
      chk("rs_after_ready", 32'(stroke_ready), 32'd1);
    end
    do_stroke(10, 12, 4, 1);

    // randomized strokes, back to back on the done cycle
    for (int i = 0; i < 12; i++) begin
      int px = $urandom_range(H + 3, 0);
      int py = $urandom_range(V + 3, 0);
      int c  = $urandom_range(7, 1);
      int r  = $urandom_range(3, 0);
      if (i % 3 == 0) begin
        px = $urandom_range(3, 0);
        py = $urandom_range(V - 1, V - 4);
      end
      do_stroke(px, py, c, r);
    end
    tick();
    chk("final_done", 32'(done), 32'd0);
    chk("final_ready", 32'(stroke_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
